// File: rtl/house_sensor_frontend.sv
// house_sensor_frontend: doorbell debounce/ring pulse, day/night hysteresis,
// and temperature conditioning for the house controller.
// Build option: define TEMP_AVG_EN to enable the 4-sample rounded temperature
// average; without it temp_req is the last valid temp_code, zero-extended.
module house_sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES  = 16,
  parameter int unsigned RING_HOLD_CYCLES = 8,
  parameter logic [11:0] DAY_ON           = 12'd800,
  parameter logic [11:0] DAY_OFF          = 12'd600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        door_btn,
  input  logic [11:0] lux,
  input  logic [7:0]  temp_code,
  input  logic        temp_valid,
  output logic        ring_req,
  output logic        isday,
  output logic [31:0] temp_req
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RING_W = $clog2(RING_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  logic              sync_p0;
  logic              sync_p1;
  db_state_t         state;
  logic [DB_W-1:0]   db_cnt;
  logic [RING_W-1:0] ring_cnt;

  // Stage p0/p1: two-flop synchronizer for the asynchronous door contact
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= door_btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce FSM; only the PRESS_WAIT->HELD edge arms the ring counter, so a
  // bounce during release (RELEASE_WAIT->HELD) never yields a second pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      db_cnt   <= '0;
      ring_cnt <= '0;
      ring_req <= 1'b0;
    end else begin
      ring_req <= (ring_cnt != '0);
      if (ring_cnt != '0) begin
        ring_cnt <= ring_cnt - RING_W'(1);
      end
      case (state)
        IDLE: begin
          if (sync_p1) begin
            state  <= PRESS_WAIT;
            db_cnt <= DB_W'(1);
          end else begin
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_p1) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state    <= HELD;
            db_cnt   <= '0;
            ring_cnt <= RING_W'(RING_HOLD_CYCLES);
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!sync_p1) begin
            state  <= RELEASE_WAIT;
            db_cnt <= DB_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sync_p1) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Day/night flag with hysteresis band between DAY_OFF and DAY_ON
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      isday <= 1'b0;
    end else if (lux >= DAY_ON) begin
      isday <= 1'b1;
    end else if (lux <= DAY_OFF) begin
      isday <= 1'b0;
    end
  end

`ifdef TEMP_AVG_EN
  logic [3:0][7:0] win_p0;
  logic [2:0]      fill_p0;
  logic [2:0]      fill_nxt;
  logic [9:0]      sum_nxt;

  // Round-half-up divide by four; 10 bits hold 4*255+2 without overflow
  function automatic logic [7:0] round_avg4(input logic [9:0] sum);
    logic [9:0] biased;
    biased = sum + 10'd2;
    return biased[9:2];
  endfunction

  // Window sum as it will be after the incoming sample displaces the oldest
  always_comb begin
    sum_nxt  = 10'(temp_code) + 10'(win_p0[0]) + 10'(win_p0[1]) + 10'(win_p0[2]);
    fill_nxt = (fill_p0 == 3'd4) ? 3'd4 : fill_p0 + 3'd1;
  end

  // Stage p0: sample window shift and output update on each valid sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_p0   <= '0;
      fill_p0  <= 3'd0;
      temp_req <= 32'd24;
    end else if (temp_valid) begin
      win_p0   <= {win_p0[2:0], temp_code};
      fill_p0  <= fill_nxt;
      temp_req <= (fill_nxt == 3'd4) ? {24'b0, round_avg4(sum_nxt)}
                                     : {24'b0, temp_code};
    end
  end
`else
  // Stage p0: capture each valid sample directly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      temp_req <= 32'd24;
    end else if (temp_valid) begin
      temp_req <= {24'b0, temp_code};
    end
  end
`endif

endmodule

// File: tb/tb_house_sensor_frontend.sv
// Directed bench for house_sensor_frontend (default or TEMP_AVG_EN build).
module tb_house_sensor_frontend;

  logic        clock;
  logic        reset;
  logic        door_btn;
  logic [11:0] lux;
  logic [7:0]  temp_code;
  logic        temp_valid;
  logic        ring_req;
  logic        isday;
  logic [31:0] temp_req;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  house_sensor_frontend dut (
    .clock      (clock),
    .reset      (reset),
    .door_btn   (door_btn),
    .lux        (lux),
    .temp_code  (temp_code),
    .temp_valid (temp_valid),
    .ring_req   (ring_req),
    .isday      (isday),
    .temp_req   (temp_req)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] lux;
    logic        exp;
  } lux_vec_t;

  typedef struct {
    logic [7:0]  code;
    logic [31:0] exp;
  } temp_vec_t;

  localparam int NL = 10;
`ifdef TEMP_AVG_EN
  localparam int NT = 8;
`else
  localparam int NT = 4;
`endif

  lux_vec_t  lv [NL];
  temp_vec_t tv [NT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic door_level(input int mode, input int i);
    case (mode)
      0:       return (i < 40);
      1:       return (i < 100) && (((i / 5) % 2) == 0);
      default: return (i < 30) || (i >= 34 && i < 60);
    endcase
  endfunction

  // Drives a door pattern and reports first ring edge index, high cycles, pulses
  task automatic run_door(input int mode, input int cycles,
                          output int rise, output int highs, output int pulses);
    logic prev;
    rise = -1; highs = 0; pulses = 0; prev = ring_req;
    for (int i = 0; i < cycles; i++) begin
      door_btn = door_level(mode, i);
      tick();
      if (ring_req) begin
        highs++;
        if (rise < 0) rise = i + 1;
        if (!prev) pulses++;
      end
      prev = ring_req;
    end
    door_btn = 1'b0;
  endtask

  initial begin
    int rise, highs, pulses;

    lv[0] = '{12'd0,    1'b0};
    lv[1] = '{12'd700,  1'b0};
    lv[2] = '{12'd800,  1'b1};
    lv[3] = '{12'd700,  1'b1};
    lv[4] = '{12'd600,  1'b0};
    lv[5] = '{12'd799,  1'b0};
    lv[6] = '{12'd601,  1'b0};
    lv[7] = '{12'd4095, 1'b1};
    lv[8] = '{12'd601,  1'b1};
    lv[9] = '{12'd0,    1'b0};

`ifdef TEMP_AVG_EN
    tv[0] = '{8'd20,  32'd20};
    tv[1] = '{8'd22,  32'd22};
    tv[2] = '{8'd30,  32'd30};
    tv[3] = '{8'd31,  32'd26};
    tv[4] = '{8'd255, 32'd85};
    tv[5] = '{8'd255, 32'd143};
    tv[6] = '{8'd255, 32'd199};
    tv[7] = '{8'd255, 32'd255};
`else
    tv[0] = '{8'd20,  32'd20};
    tv[1] = '{8'd30,  32'd30};
    tv[2] = '{8'd0,   32'd0};
    tv[3] = '{8'd255, 32'd255};
`endif

    reset = 1'b0; door_btn = 1'b0; lux = '0; temp_code = '0; temp_valid = 1'b0;
    #12;
    check("reset ring_req", 32'(ring_req), 32'd0);
    check("reset isday", 32'(isday), 32'd0);
    check("reset temp_req", temp_req, 32'd24);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();

    // lux hysteresis table, each value held 3 cycles
    for (int k = 0; k < NL; k++) begin
      lux = lv[k].lux;
      repeat (3) tick();
      check($sformatf("isday lux=%0d", lv[k].lux), 32'(isday), 32'(lv[k].exp));
    end

    // temperature table: latency, hold while invalid, ignore code when invalid
    for (int k = 0; k < NT; k++) begin
      logic [31:0] prev_exp;
      prev_exp = (k == 0) ? 32'd24 : tv[k-1].exp;
      temp_code = tv[k].code; temp_valid = 1'b1;
      #1;
      check($sformatf("temp pre-edge %0d", k), temp_req, prev_exp);
      tick();
      temp_valid = 1'b0; temp_code = 8'hA5;
      check($sformatf("temp after %0d", k), temp_req, tv[k].exp);
      tick();
      check($sformatf("temp hold %0d", k), temp_req, tv[k].exp);
    end

    // single 40-cycle press
    run_door(0, 80, rise, highs, pulses);
    check("press rise cycle", 32'(rise), 32'd19);
    check("press high cycles", 32'(highs), 32'd8);
    check("press pulse count", 32'(pulses), 32'd1);

    // bounce every 5 cycles never qualifies
    run_door(1, 130, rise, highs, pulses);
    check("bounce high cycles", 32'(highs), 32'd0);

    // short release glitch while held still yields one pulse
    run_door(2, 100, rise, highs, pulses);
    check("glitch rise cycle", 32'(rise), 32'd19);
    check("glitch pulse count", 32'(pulses), 32'd1);
    check("glitch high cycles", 32'(highs), 32'd8);

    // asynchronous reset mid-ring and mid-fill
    temp_code = 8'd40; temp_valid = 1'b1; tick();
    temp_code = 8'd50; tick();
    temp_valid = 1'b0;
    lux = 12'd900;
    door_btn = 1'b1;
    repeat (21) tick();
    check("pre-reset ring_req", 32'(ring_req), 32'd1);
    check("pre-reset isday", 32'(isday), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset ring_req", 32'(ring_req), 32'd0);
    check("async reset isday", 32'(isday), 32'd0);
    check("async reset temp_req", temp_req, 32'd24);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("held reset ring_req", 32'(ring_req), 32'd0);

    // release with door still high: full sync + debounce, plus first sample
    reset = 1'b1;
    temp_code = 8'd18; temp_valid = 1'b1;
    rise = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        temp_valid = 1'b0; temp_code = 8'h00;
        check("post-reset temp_req", temp_req, 32'd18);
      end
      if (ring_req && rise < 0) rise = i;
    end
    check("post-reset ring rise", 32'(rise), 32'd19);
    door_btn = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/house_sensor_frontend.md
HOUSE_SENSOR_FRONTEND -- requirements
Module: house_sensor_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive cycles the synchronized door_btn must hold a new level before that level is accepted.
REQ-002 Parameter RING_HOLD_CYCLES, default 8, is the number of cycles ring_req stays high per accepted press.
REQ-003 Parameter DAY_ON, default 12'd800, is the lux threshold at or above which isday sets.
REQ-004 Parameter DAY_OFF, default 12'd600, is the lux threshold at or below which isday clears; DAY_OFF < DAY_ON.
REQ-005 Port clock, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous reset, active-low.
REQ-007 Port door_btn, input, 1: raw doorbell contact, asynchronous, bouncy, 1 = pressed.
REQ-008 Port lux, input, 12: ambient light level, unsigned, sampled every cycle.
REQ-009 Port temp_code, input, 8: room temperature in whole degrees C, unsigned.
REQ-010 Port temp_valid, input, 1: single-cycle strobe qualifying temp_code.
REQ-011 Port ring_req, output, 1: conditioned doorbell request to the house controller.
REQ-012 Port isday, output, 1: day indication with hysteresis.
REQ-013 Port temp_req, output, 32: conditioned temperature, zero-extended to 32 bits.

Function
REQ-014 door_btn shall pass through a 2-flop synchronizer before any other logic.
REQ-015 The debouncer shall be a state machine with states IDLE, PRESS_WAIT, HELD, and RELEASE_WAIT.
REQ-016 Debouncer transitions:
- IDLE -> PRESS_WAIT when sync=1.
- PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive sync=1 cycles; any sync=0 returns to IDLE and clears the counter.
- HELD -> RELEASE_WAIT when sync=0.
- RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive sync=0 cycles; any sync=1 returns to HELD.
REQ-017 Entry into HELD shall load the ring counter with RING_HOLD_CYCLES; ring_req shall be high while the counter is nonzero, decrementing once per cycle.
REQ-018 Exactly one ring pulse shall be produced per accepted press, regardless of how long the press is held.
REQ-019 A new press accepted while ring_req is still high shall reload the counter; pulses shall not queue.
REQ-020 isday shall be registered and update as follows:
- Set when lux >= DAY_ON.
- Clear when lux <= DAY_OFF.
- Hold its value when DAY_OFF < lux < DAY_ON.
REQ-021 On a temp_valid cycle, temp_code shall enter a 4-entry sample window, and a fill count (0..4, saturating) shall increment.
REQ-022 temp_req shall update on the clock edge following a temp_valid cycle, giving a latency of 1 cycle.
REQ-023 While the fill count is below 4 after the update, temp_req shall equal the newest sample.
REQ-024 Once the fill count reaches 4, temp_req shall equal (sum of the 4 samples + 2) >> 2.
REQ-025 The sum shall be 10 bits wide so that no overflow occurs at 4 x 255.
REQ-026 When temp_valid is low, temp_req shall hold its value.
REQ-027 temp_code shall be ignored when temp_valid is low.

Reset
REQ-028 Asserting reset (low) shall immediately force the following, asynchronously and at any point mid-operation:
- Debouncer to IDLE; ring counter to 0; ring_req to 0.
- isday to 0.
- temp_req to 32'd24; fill count to 0.
- Sample window and synchronizer flops to 0.
REQ-029 After reset release, the first rising edge shall operate normally, and a door_btn held high through reset shall require the full synchronizer and debounce time before ring_req asserts.

Configuration
REQ-030 Macro TEMP_AVG_EN shall control temperature averaging.
REQ-031 With TEMP_AVG_EN defined, the 4-sample averaging of REQ-021 to REQ-025 applies.
REQ-032 Without TEMP_AVG_EN defined, no window or fill count shall be built, and temp_req shall equal {24'b0, temp_code} captured on each temp_valid cycle, with the same 1-cycle latency.

Verification
REQ-033 door_btn high for 40 cycles -> ring_req rises 2 + 16 + 1 cycles after the edge, stays high exactly 8 cycles, and only one pulse occurs.
REQ-034 door_btn toggled every 5 cycles for 100 cycles -> ring_req stays 0 throughout.
REQ-035 lux sweep 0 -> 700 -> 800 -> 700 -> 600 -> isday reads 0, 0, 1, 1, 0 (each value held 3 cycles).
REQ-036 temp_valid with temp_code = 20, 22, 30, 31 (TEMP_AVG_EN) -> temp_req = 20, 22, 30, then (103 + 2) >> 2 = 26; then 255 x4 -> 255.
REQ-037 reset pulled low mid-ring and mid-fill -> ring_req = 0, isday = 0, temp_req = 24 without waiting for a clock edge; the next sample of 18 gives temp_req = 18.
REQ-038 Build without TEMP_AVG_EN, temp_code = 20 then 30 -> temp_req = 20, then 30, each one cycle after its temp_valid.
